// File: rtl/period_marker_generator.sv
// Programmable-period, programmable-width counter_reset marker train with start/stop and status.
// Optional PERIOD_SHADOW_UPDATE_EN: re-sample period/pulse_width into the shadows at every period wrap.
module period_marker_generator #(
   parameter int PERIOD_WIDTH = 32,
   parameter int REP_WIDTH    = 32
) (
   input  logic                    clk,
   input  logic                    aresetn,
   input  logic                    start,
   input  logic                    stop,
   input  logic [PERIOD_WIDTH-1:0] period,
   input  logic [PERIOD_WIDTH-1:0] pulse_width,
   input  logic [REP_WIDTH-1:0]    num_periods,
   output logic                    counter_reset,
   output logic                    period_start,
   output logic [REP_WIDTH-1:0]    period_index,
   output logic                    busy,
   output logic                    done
);

   typedef enum logic {IDLE, RUN} state_t;

   state_t                  state_q, state_d;
   logic [PERIOD_WIDTH-1:0] cnt_q, cnt_d;
   logic [PERIOD_WIDTH-1:0] period_s_q, period_s_d;
   logic [PERIOD_WIDTH-1:0] pw_s_q, pw_s_d;
   logic [REP_WIDTH-1:0]    num_s_q, num_s_d;
   logic [REP_WIDTH-1:0]    idx_q, idx_d;
   logic                    cr_q, cr_d;
   logic                    ps_q, ps_d;
   logic                    busy_q, busy_d;
   logic                    done_q, done_d;

   function automatic logic [PERIOD_WIDTH-1:0] clamp_period(input logic [PERIOD_WIDTH-1:0] p);
      return (p < PERIOD_WIDTH'(2)) ? PERIOD_WIDTH'(2) : p;
   endfunction

   // Width is clamped against the already-clamped period so the marker is always low >= 1 cycle.
   function automatic logic [PERIOD_WIDTH-1:0] clamp_width(input logic [PERIOD_WIDTH-1:0] w,
                                                           input logic [PERIOD_WIDTH-1:0] p_eff);
      if (w == '0)
         return PERIOD_WIDTH'(1);
      else if (w >= p_eff)
         return p_eff - PERIOD_WIDTH'(1);
      else
         return w;
   endfunction

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      period_s_d = period_s_q;
      pw_s_d     = pw_s_q;
      num_s_d    = num_s_q;
      idx_d      = idx_q;
      done_d     = 1'b0;

      case (state_q)
         IDLE: begin
            if (start && !stop) begin
               state_d    = RUN;
               period_s_d = clamp_period(period);
               pw_s_d     = clamp_width(pulse_width, clamp_period(period));
               num_s_d    = num_periods;
               cnt_d      = '0;
               idx_d      = '0;
            end
         end
         RUN: begin
            if (stop) begin
               state_d = IDLE;
               cnt_d   = '0;
               idx_d   = '0;
            end else if (cnt_q == period_s_q - PERIOD_WIDTH'(1)) begin
               cnt_d = '0;
               if ((num_s_q != '0) && (idx_q == num_s_q - REP_WIDTH'(1))) begin
                  state_d = IDLE;
                  idx_d   = '0;
                  done_d  = 1'b1;
               end else begin
                  idx_d = idx_q + REP_WIDTH'(1);
`ifdef PERIOD_SHADOW_UPDATE_EN
                  period_s_d = clamp_period(period);
                  pw_s_d     = clamp_width(pulse_width, clamp_period(period));
`endif
               end
            end else begin
               cnt_d = cnt_q + PERIOD_WIDTH'(1);
            end
         end
         default: state_d = IDLE;
      endcase

      // Outputs are derived from next-state values so they are registered alongside the state.
      busy_d = (state_d == RUN);
      cr_d   = busy_d && (cnt_d < pw_s_d);
      ps_d   = busy_d && (cnt_d == '0);
   end

   always_ff @(posedge clk) begin
      if (aresetn) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         period_s_q <= '0;
         pw_s_q     <= '0;
         num_s_q    <= '0;
         idx_q      <= '0;
         cr_q       <= 1'b0;
         ps_q       <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         period_s_q <= period_s_d;
         pw_s_q     <= pw_s_d;
         num_s_q    <= num_s_d;
         idx_q      <= idx_d;
         cr_q       <= cr_d;
         ps_q       <= ps_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   assign counter_reset = cr_q;
   assign period_start  = ps_q;
   assign period_index  = idx_q;
   assign busy          = busy_q;
   assign done          = done_q;

endmodule

// File: tb/tb_period_marker_generator.sv
// Scoreboard bench for period_marker_generator: a timeline reference model predicts every
// output cycle; a monitor pops and compares one prediction per clock.
module tb_period_marker_generator;

   logic        clk = 1'b0;
   logic        aresetn, start, stop;
   logic [31:0] period, pulse_width, num_periods;
   logic        counter_reset, period_start, busy, done;
   logic [31:0] period_index;

   always #5 clk = ~clk;

   period_marker_generator #(.PERIOD_WIDTH(32), .REP_WIDTH(32)) dut (
      .clk           (clk),
      .aresetn       (aresetn),
      .start         (start),
      .stop          (stop),
      .period        (period),
      .pulse_width   (pulse_width),
      .num_periods   (num_periods),
      .counter_reset (counter_reset),
      .period_start  (period_start),
      .period_index  (period_index),
      .busy          (busy),
      .done          (done)
   );

`ifdef PERIOD_SHADOW_UPDATE_EN
   localparam bit SHADOW = 1'b1;
`else
   localparam bit SHADOW = 1'b0;
`endif

   typedef struct packed {
      logic        cr;
      logic        ps;
      logic [31:0] idx;
      logic        busy;
      logic        done;
   } exp_t;

   exp_t exp_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   // Reference model: a running sequence is a segment starting at cycle m_t0 with constant
   // period m_P and width m_W; outputs for cycle c follow from (c - m_t0) by division/modulo.
   bit     m_active = 1'b0;
   longint m_cyc    = 0;
   longint m_t0     = 0;
   longint m_P      = 2;
   longint m_W      = 1;
   longint m_idx0   = 0;
   longint m_N      = 0;

   function automatic longint eff_period(input longint p);
      return (p < 2) ? 2 : p;
   endfunction

   function automatic longint eff_width(input longint w, input longint p);
      if (w == 0) return 1;
      if (w >= p) return p - 1;
      return w;
   endfunction

   task automatic model_step(input logic s, input logic sp, input logic r);
      exp_t   e;
      longint c, k, pos;
      bit     done_f;
      done_f = 1'b0;
      c = m_cyc + 1;
      if (r) begin
         m_active = 1'b0;
      end else if (!m_active) begin
         if (s && !sp) begin
            m_active = 1'b1;
            m_t0     = c;
            m_P      = eff_period(longint'(period));
            m_W      = eff_width(longint'(pulse_width), m_P);
            m_N      = longint'(num_periods);
            m_idx0   = 0;
         end
      end else if (sp) begin
         m_active = 1'b0;
      end else begin
         k   = m_cyc - m_t0;
         pos = k % m_P;
         if (pos == m_P - 1) begin
            if (m_N != 0 && (m_idx0 + k / m_P) == m_N - 1) begin
               m_active = 1'b0;
               done_f   = 1'b1;
            end else if (SHADOW) begin
               m_idx0 = m_idx0 + k / m_P + 1;
               m_t0   = c;
               m_P    = eff_period(longint'(period));
               m_W    = eff_width(longint'(pulse_width), m_P);
            end
         end
      end
      e      = '0;
      e.done = done_f;
      if (m_active) begin
         k      = c - m_t0;
         pos    = k % m_P;
         e.cr   = (pos < m_W);
         e.ps   = (pos == 0);
         e.idx  = 32'(m_idx0 + k / m_P);
         e.busy = 1'b1;
      end
      exp_q.push_back(e);
      m_cyc = c;
   endtask

   task automatic drive(input logic s, input logic sp, input logic r);
      start   = s;
      stop    = sp;
      aresetn = r;
      model_step(s, sp, r);
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0);
   endtask

   // Monitor: one expected record per clock edge.
   initial begin
      exp_t e;
      longint mc;
      mc = 0;
      forever begin
         @(posedge clk);
         #1;
         mc++;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_tests += 5;
            if (counter_reset !== e.cr) begin
               n_fail++;
               $display("FAIL counter_reset cycle=%0d got=%b exp=%b", mc, counter_reset, e.cr);
            end
            if (period_start !== e.ps) begin
               n_fail++;
               $display("FAIL period_start cycle=%0d got=%b exp=%b", mc, period_start, e.ps);
            end
            if (period_index !== e.idx) begin
               n_fail++;
               $display("FAIL period_index cycle=%0d got=%0d exp=%0d", mc, period_index, e.idx);
            end
            if (busy !== e.busy) begin
               n_fail++;
               $display("FAIL busy cycle=%0d got=%b exp=%b", mc, busy, e.busy);
            end
            if (done !== e.done) begin
               n_fail++;
               $display("FAIL done cycle=%0d got=%b exp=%b", mc, done, e.done);
            end
         end
      end
   end

   initial begin
      logic s, sp, rr;
      start = 1'b0; stop = 1'b0; aresetn = 1'b1;
      period = 32'd10; pulse_width = 32'd3; num_periods = 32'd4;

      // Reset and quiet idle
      drive(1'b0, 1'b0, 1'b1);
      drive(1'b0, 1'b0, 1'b1);
      drive(1'b0, 1'b0, 1'b1);
      idle(2);

      // Bounded: 10/3/4, done at cycle 40 after first marker
      period = 32'd10; pulse_width = 32'd3; num_periods = 32'd4;
      drive(1'b1, 1'b0, 1'b0);
      idle(45);

      // Clamping: period 1/width 0, then period 5/width 9
      period = 32'd1; pulse_width = 32'd0; num_periods = 32'd3;
      drive(1'b1, 1'b0, 1'b0);
      idle(10);
      period = 32'd5; pulse_width = 32'd9; num_periods = 32'd2;
      drive(1'b1, 1'b0, 1'b0);
      idle(14);

      // Unbounded, stop at cnt=5 of period 2, then restart
      period = 32'd8; pulse_width = 32'd2; num_periods = 32'd0;
      drive(1'b1, 1'b0, 1'b0);
      idle(21);
      drive(1'b0, 1'b1, 1'b0);
      idle(3);
      num_periods = 32'd2;
      drive(1'b1, 1'b0, 1'b0);
      idle(20);

      // start+stop together in IDLE, then start ignored during RUN
      drive(1'b1, 1'b1, 1'b0);
      idle(5);
      period = 32'd7; pulse_width = 32'd2; num_periods = 32'd3;
      drive(1'b1, 1'b0, 1'b0);
      idle(5);
      drive(1'b1, 1'b0, 1'b0);
      idle(20);

      // Reset during counter_reset high phase, stays idle afterwards
      period = 32'd10; pulse_width = 32'd4; num_periods = 32'd0;
      drive(1'b1, 1'b0, 1'b0);
      idle(2);
      drive(1'b0, 1'b0, 1'b1);
      idle(6);

      // Period change at cnt=4 (takes effect next period only when shadow update is built in)
      period = 32'd10; pulse_width = 32'd3; num_periods = 32'd4;
      drive(1'b1, 1'b0, 1'b0);
      idle(4);
      period = 32'd6;
      idle(36);

      // Randomized sequences
      for (int r = 0; r < 30; r++) begin
         period      = 32'($urandom_range(0, 12));
         pulse_width = 32'($urandom_range(0, 14));
         num_periods = 32'($urandom_range(0, 4));
         drive(1'b1, 1'b0, 1'b0);
         for (int i = 0; i < 40; i++) begin
            s  = ($urandom_range(0, 9) == 0);
            sp = ($urandom_range(0, 29) == 0);
            rr = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 19) == 0) period = 32'($urandom_range(0, 12));
            if ($urandom_range(0, 19) == 0) pulse_width = 32'($urandom_range(0, 14));
            if ($urandom_range(0, 19) == 0) num_periods = 32'($urandom_range(0, 4));
            drive(s, sp, rr);
         end
      end

      @(posedge clk);
      #2;
      n_tests++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain got=%0d left exp=0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/period_marker_generator.md
# period_marker_generator

Generates the periodic `counter_reset` frame-marker pulses that the delayed-trigger counters consume to measure period length and fire early triggers. It sits in the sequencing fabric, upstream of every period-measuring trigger block, and is driven from the control registers. It produces a programmable-period, programmable-width pulse train for a bounded or unbounded number of periods, with start/stop control and status.

## Interface
- `PERIOD_WIDTH`, 32: width of the period, counter and pulse-width paths.
- `REP_WIDTH`, 32: width of the period-count and period-index paths.
- `clk`  in  1  system clock; all logic on the rising edge.
- `aresetn`  in  1  synchronous reset, active-high; asserted when 1.
- `start`  in  1  one-cycle request to begin a sequence.
- `stop`  in  1  one-cycle request to abort a sequence.
- `period`  in  PERIOD_WIDTH  clock cycles per period.
- `pulse_width`  in  PERIOD_WIDTH  high cycles of `counter_reset` per period.
- `num_periods`  in  REP_WIDTH  periods to emit; 0 means unbounded.
- `counter_reset`  out  1  frame marker, high at the start of each period.
- `period_start`  out  1  one-cycle strobe on the first cycle of each period.
- `period_index`  out  REP_WIDTH  index of the current period, starting at 0.
- `busy`  out  1  high while a sequence is running.
- `done`  out  1  one-cycle strobe when a bounded sequence completes.

## Operation
- **FSM states:** IDLE and RUN.
- **IDLE:** all outputs are 0. `start`=1 with `stop`=0 loads the shadow registers (`period_s`, `pw_s`, `num_s`), clears `cnt` and `period_index`, and moves to RUN.
- **RUN, counter:** `cnt` counts 0 .. `period_s`-1 and then wraps to 0.
- **RUN, `counter_reset`:** high while `cnt` < `pw_s`.
- **RUN, `period_start`:** high while `cnt` == 0.
- **Period wrap (`cnt` == `period_s`-1):**
  - If `num_s` != 0 and `period_index` == `num_s`-1: go to IDLE and pulse `done` for one cycle.
  - Otherwise: increment `period_index`, which wraps modulo 2^REP_WIDTH when unbounded.
- **Clamping, applied at every shadow load:**
  - `period` < 2 is treated as 2.
  - `pulse_width` == 0 is treated as 1.
  - `pulse_width` >= period is treated as period-1.
  - Together these keep `counter_reset` low for at least one cycle per period, which downstream counters need to re-arm their edge detection.
- **Stop:** `stop`=1 in RUN goes to IDLE on the next edge. Outputs drop at that edge, mid-period or not. `done` is not pulsed.
- **Simultaneous events:**
  - `start` and `stop` in the same cycle: `stop` wins, and the block stays or goes IDLE.
  - `start` in RUN is ignored.
- **Reset:** `aresetn`=1 forces IDLE and zeroes every register and output at the next edge, regardless of state, including mid-period.

## Timing
- **Output reset values:** `counter_reset`, `period_start`, `busy` and `done` are 0; `period_index` is 0.
- **Start latency:** `start` sampled at edge T gives `busy`, `counter_reset` and `period_start` all equal to 1 in the cycle after T. That cycle is `cnt`=0.
- **Registered outputs:** all outputs are registered; there are no combinational input-to-output paths.
- **Period spacing:** successive `period_start` strobes are exactly `period_s` cycles apart.
- **Pulse width:** `counter_reset` is high for exactly `pw_s` cycles per period.
- **Completion:** for N periods with period P, the first `period_start` is at cycle 0 and `done` is high at cycle N·P. `busy` is low from cycle N·P onward, and no `counter_reset` appears at N·P.
- **`period_index`:** updates on the same cycle `period_start` rises.
- **Stop latency:** `stop` at edge T gives all outputs 0 in the cycle after T.

## Configuration
- **Macro:** `PERIOD_SHADOW_UPDATE_EN`.
- **Defined:** `period` and `pulse_width` are re-sampled and re-clamped into the shadow registers at every period wrap. A new value takes effect from the next period's `cnt`=0 and never alters a period in progress. `num_periods` is still sampled only at start.
- **Undefined:** all three inputs are sampled only at start and are constant for the whole sequence.

## Test plan
- **Bounded sequence:** `period`=10, `pulse_width`=3, `num_periods`=4, `start` pulse → `counter_reset` high for 3 cycles every 10 cycles; `period_index` steps 0,1,2,3; `done` pulses at cycle 40 after the first marker; `busy` falls the same cycle.
- **Clamping:** `period`=1, `pulse_width`=0 → effective period 2 and width 1, so `counter_reset` alternates 1,0. In a separate run, `period`=5, `pulse_width`=9 → high 4 cycles, low 1.
- **Stop mid-period:** `num_periods`=0, `period`=8, `stop` at `cnt`=5 of period 2 → all outputs 0 the next cycle, no `done`; a later `start` restarts at `period_index`=0.
- **Simultaneous and ignored start:** `start` and `stop` in the same cycle while IDLE → no activity. `start` asserted during RUN → period spacing unaffected.
- **Reset mid-sequence:** `aresetn`=1 during the high phase of `counter_reset` → every output 0 at the next edge, and the block stays IDLE after `aresetn` deasserts.
- **Shadow update (macro defined):** change `period` from 10 to 6 at `cnt`=4 → the current period still lasts 10 cycles, and the following periods last 6.
